// File: rtl/parallel_adder.sv
// parallel_adder: ripple-carry adder with a registered, valid-qualified copy of the result.
// Define PARALLEL_ADDER_OVF_EN to add two's-complement overflow outputs ovf/ovf_q.
module parallel_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             out_valid
`ifdef PARALLEL_ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);
`ifdef PARALLEL_ADDER_OVF_EN
    localparam int RW = WIDTH + 2;
`else
    localparam int RW = WIDTH + 1;
`endif
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] p;
    logic [RW-1:0]    res;
    logic [RW-1:0]    res_d;
    logic [RW-1:0]    res_q;
    logic             valid_q;
    assign c[0] = cin;
    assign p    = a ^ b;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = p[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & p[i]);
    end
    assign cout = c[WIDTH];
`ifdef PARALLEL_ADDER_OVF_EN
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    assign res   = {ovf, cout, s};
    assign ovf_q = res_q[WIDTH+1];
`else
    assign res = {cout, s};
`endif
    always_comb begin
        res_d = in_valid ? res : res_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= in_valid;
        end
    end
    assign s_q       = res_q[WIDTH-1:0];
    assign cout_q    = res_q[WIDTH];
    assign out_valid = valid_q;
endmodule

// File: tb/tb_parallel_adder.sv
// tb_parallel_adder: directed-vector bench for parallel_adder (WIDTH=4).
module tb_parallel_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] s;
    logic       cout;
    logic [3:0] s_q;
    logic       cout_q;
    logic       out_valid;
`ifdef PARALLEL_ADDER_OVF_EN
    logic       ovf;
    logic       ovf_q;
`endif
    int n_chk  = 0;
    int n_pass = 0;

    parallel_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q), .out_valid(out_valid)
`ifdef PARALLEL_ADDER_OVF_EN
        , .ovf(ovf), .ovf_q(ovf_q)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        a = va;
        b = vb;
        cin = vc;
        #1;
    endtask

    initial begin
        #2;
        chk("rst_s_q", s_q, 0);
        chk("rst_cout_q", cout_q, 0);
        chk("rst_out_valid", out_valid, 0);
        // in_valid during reset must be discarded
        drive(3, 4, 0);
        in_valid = 1'b1;
        edge1();
        chk("rst_discard_valid", out_valid, 0);
        chk("rst_discard_s_q", s_q, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        drive(3, 8, 1);
        chk("v1_s", s, 12);
        chk("v1_cout", cout, 0);
        in_valid = 1'b1;
        edge1();
        chk("v1_s_q", s_q, 12);
        chk("v1_cout_q", cout_q, 0);
        chk("v1_out_valid", out_valid, 1);
        in_valid = 1'b0;
        drive(9, 6, 0);
        chk("v2_s", s, 15);
        chk("v2_cout", cout, 0);
        edge1();
        chk("hold_out_valid", out_valid, 0);
        chk("hold_s_q", s_q, 12);
        drive(10, 10, 1);
        chk("v3_s", s, 5);
        chk("v3_cout", cout, 1);
        drive(15, 0, 1);
        chk("ripple_s", s, 0);
        chk("ripple_cout", cout, 1);
        drive(15, 15, 1);
        chk("max_s", s, 15);
        chk("max_cout", cout, 1);
        // three back-to-back captures, then idle
        drive(1, 2, 0);
        in_valid = 1'b1;
        edge1();
        chk("burst1_s_q", s_q, 3);
        chk("burst1_valid", out_valid, 1);
        drive(4, 4, 1);
        edge1();
        chk("burst2_s_q", s_q, 9);
        chk("burst2_valid", out_valid, 1);
        drive(7, 8, 0);
        edge1();
        chk("burst3_s_q", s_q, 15);
        chk("burst3_valid", out_valid, 1);
        in_valid = 1'b0;
        drive(0, 0, 0);
        edge1();
        chk("post1_valid", out_valid, 0);
        chk("post1_s_q", s_q, 15);
        edge1();
        chk("post2_valid", out_valid, 0);
        chk("post2_s_q", s_q, 15);
        // carry-out capture
        drive(15, 1, 0);
        in_valid = 1'b1;
        edge1();
        chk("cap_cout_q", cout_q, 1);
        chk("cap_s_q0", s_q, 0);
        // mid-stream reset
        drive(5, 6, 0);
        edge1();
        chk("pre_rst_s_q", s_q, 11);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_s_q", s_q, 0);
        chk("mid_rst_cout_q", cout_q, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_comb_s", s, 11);
        edge1();
        chk("rst_edge_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rel_valid", out_valid, 0);
        edge1();
        chk("first_cap_s_q", s_q, 11);
        chk("first_cap_valid", out_valid, 1);
        in_valid = 1'b0;
`ifdef PARALLEL_ADDER_OVF_EN
        drive(7, 1, 0);
        chk("ovf_7_1", ovf, 1);
        in_valid = 1'b1;
        edge1();
        chk("ovf_q_7_1", ovf_q, 1);
        in_valid = 1'b0;
        drive(8, 8, 0);
        chk("ovf_8_8", ovf, 1);
        chk("ovf_8_8_cout", cout, 1);
        drive(3, 2, 0);
        chk("ovf_3_2", ovf, 0);
        rst = 1'b1;
        #1;
        chk("ovf_q_rst", ovf_q, 0);
        rst = 1'b0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/parallel_adder.md
PARALLEL_ADDER -- requirements
Module: parallel_adder

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 4: operand width in bits; legal range 1..32.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all registers rise-edge triggered.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port a, input, WIDTH bits: unsigned addend A.
REQ-005 The block SHALL have port b, input, WIDTH bits: unsigned addend B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: qualifies a/b/cin for capture into the registered stage.
REQ-008 The block SHALL have port s, output, WIDTH bits: combinational sum.
REQ-009 The block SHALL have port cout, output, 1 bit: combinational carry-out of the MSB.
REQ-010 The block SHALL have port s_q, output, WIDTH bits: registered sum.
REQ-011 The block SHALL have port cout_q, output, 1 bit: registered carry-out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: s_q/cout_q hold a result captured on the previous edge.

Function
REQ-013 {cout,s} SHALL equal a + b + cin, computed as a (WIDTH+1)-bit unsigned sum, with zero cycle latency and purely combinational logic.
REQ-014 The adder SHALL be a ripple-carry chain of WIDTH full-adder cells:
- cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
- c[0] = cin; cout = c[WIDTH]
REQ-015 Wrap-around: a sum ≥ 2^WIDTH SHALL set cout=1, with s = sum mod 2^WIDTH.
REQ-016 On a clk rising edge with in_valid=1, s_q and cout_q SHALL load the current s and cout, and out_valid SHALL become 1 (one-cycle latency).
REQ-017 On a clk rising edge with in_valid=0, s_q and cout_q SHALL hold their values and out_valid SHALL become 0.
REQ-018 A back-to-back in_valid SHALL produce one result per cycle, with no bubbles and no backpressure.
REQ-019 Combinational outputs s and cout SHALL NOT be affected by rst, in_valid or clk.

Reset
REQ-020 While rst=1, s_q, cout_q and out_valid SHALL be forced to 0 immediately, independent of clk.
REQ-021 An in_valid asserted while rst=1 SHALL be discarded.
REQ-022 A capture SHALL occur no earlier than the first clk edge after rst deasserts.
REQ-023 A reset asserted mid-stream SHALL clear out_valid within the same cycle.

Configuration
REQ-024 With PARALLEL_ADDER_OVF_EN defined, the block SHALL add the following outputs:
- ovf (combinational): a, b, s interpreted as two's complement; ovf = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB])
- ovf_q (registered): same capture and reset rules as cout_q
REQ-025 With PARALLEL_ADDER_OVF_EN undefined, ports ovf and ovf_q and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 a=3, b=8, cin=1 -> s=12, cout=0; one edge after in_valid=1 -> s_q=12, cout_q=0, out_valid=1.
REQ-027 a=9, b=6, cin=0 -> s=15, cout=0; then a=10, b=10, cin=1 -> s=5, cout=1.
REQ-028 a=15, b=0, cin=1 -> s=0, cout=1 (full carry ripple); a=15, b=15, cin=1 -> s=15, cout=1.
REQ-029 Assert rst mid-stream with in_valid=1 -> s_q=0, cout_q=0, out_valid=0 immediately; first capture on the first edge after release.
REQ-030 Drive in_valid=1 for 3 cycles, then 0 -> out_valid high for exactly 3 cycles; s_q holds the last result afterwards.
REQ-031 With PARALLEL_ADDER_OVF_EN defined: a=7, b=1, cin=0 -> ovf=1; a=8, b=8 -> ovf=1, cout=1; a=3, b=2 -> ovf=0.
